// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass and a per-register pending scoreboard.
// Latency: reads and busy flags are combinational (zero cycles); writes and scoreboard updates land on the next clk edge.
// Backpressure: none; every write and issue is accepted in the cycle it is presented.
module reg_file_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] indata,
   input  logic [AW-1:0]   rs1,
   output logic [XLEN-1:0] rv1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rv2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            any_busy
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pend;

   logic wr_en;
   logic fwd1;
   logic fwd2;

   // Writes to register 0 are dropped so it always reads as zero.
   assign wr_en = we && (rd != '0);

   // Forwarding is only possible when bypass is enabled and the write targets the read index.
   assign fwd1 = (BYPASS != 0) && we && (rd == rs1);
   assign fwd2 = (BYPASS != 0) && we && (rd == rs2);

   // Data storage: cleared on reset, otherwise take the writeback value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[rd] <= indata;
      end
   end

   // Scoreboard: a new issue sets pending and outranks a retiring write to the same register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend[0] <= 1'b0;
         for (int i = 1; i < NREGS; i++) begin
            if (issue_valid && (issue_rd == AW'(i))) begin
               pend[i] <= 1'b1;
            end else if (we && (rd == AW'(i))) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   // Read ports: index 0 is zero, otherwise forward the same-cycle write or return stored data.
   always_comb begin
      rv1 = '0;
      rv2 = '0;
      if (rs1 != '0) begin
         rv1 = fwd1 ? indata : regs[rs1];
      end
      if (rs2 != '0) begin
         rv2 = fwd2 ? indata : regs[rs2];
      end
   end

   // Busy flags: a forwarded write satisfies the read this cycle, so it masks the pending bit.
   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      if (rs1 != '0) begin
         rs1_busy = pend[rs1] && !fwd1;
      end
      if (rs2 != '0) begin
         rs2_busy = pend[rs2] && !fwd2;
      end
   end

   // Summary of outstanding producers, from registered state only.
   assign any_busy = |pend[NREGS-1:1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (32x32 with bypass, 16x64 without) driven by the same stimulus.
// Outputs are sampled at the falling edge against an array-based reference model.
// The model advances at each rising edge using the inputs that were presented.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  rd;
   logic [63:0] indata;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        issue_valid;
   logic [4:0]  issue_rd;

   logic [31:0] rv1a, rv2a;
   logic        rs1_busy_a, rs2_busy_a, any_busy_a;
   logic [63:0] rv1b, rv2b;
   logic        rs1_busy_b, rs2_busy_b, any_busy_b;

   int nvec = 0;
   int nerr = 0;

   // Reference state: [0] = 32 regs x 32 bits with bypass, [1] = 16 regs x 64 bits without.
   logic [63:0] m_regs [2][32];
   bit          m_pend [2][32];

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .we(we), .rd(rd), .indata(indata[31:0]),
      .rs1(rs1), .rv1(rv1a), .rs2(rs2), .rv2(rv2a),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a), .any_busy(any_busy_a)
   );

   reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .we(we), .rd(rd[3:0]), .indata(indata),
      .rs1(rs1[3:0]), .rv1(rv1b), .rs2(rs2[3:0]), .rv2(rv2b),
      .issue_valid(issue_valid), .issue_rd(issue_rd[3:0]),
      .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .any_busy(any_busy_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int nregs(input int k);
      return (k == 0) ? 32 : 16;
   endfunction

   function automatic logic [63:0] dmask(input int k);
      return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic int ix(input int k, input logic [4:0] x);
      return int'(x) % nregs(k);
   endfunction

   function automatic bit fwd(input int k, input logic [4:0] rs);
      return (k == 0) && we && (ix(k, rd) == ix(k, rs));
   endfunction

   function automatic logic [63:0] exp_rv(input int k, input logic [4:0] rs);
      if (ix(k, rs) == 0) return 64'd0;
      if (fwd(k, rs)) return indata & dmask(k);
      return m_regs[k][ix(k, rs)];
   endfunction

   function automatic logic [63:0] exp_busy(input int k, input logic [4:0] rs);
      if (ix(k, rs) == 0) return 64'd0;
      if (fwd(k, rs)) return 64'd0;
      return {63'd0, m_pend[k][ix(k, rs)]};
   endfunction

   function automatic logic [63:0] exp_any(input int k);
      bit a = 1'b0;
      for (int i = 1; i < nregs(k); i++) a |= m_pend[k][i];
      return {63'd0, a};
   endfunction

   task automatic sample();
      @(negedge clk);
      check("a_rv1",   {32'd0, rv1a},        exp_rv(0, rs1));
      check("a_rv2",   {32'd0, rv2a},        exp_rv(0, rs2));
      check("a_busy1", {63'd0, rs1_busy_a},  exp_busy(0, rs1));
      check("a_busy2", {63'd0, rs2_busy_a},  exp_busy(0, rs2));
      check("a_any",   {63'd0, any_busy_a},  exp_any(0));
      check("b_rv1",   rv1b,                 exp_rv(1, rs1));
      check("b_rv2",   rv2b,                 exp_rv(1, rs2));
      check("b_busy1", {63'd0, rs1_busy_b},  exp_busy(1, rs1));
      check("b_busy2", {63'd0, rs2_busy_b},  exp_busy(1, rs2));
      check("b_any",   {63'd0, any_busy_b},  exp_any(1));
   endtask

   // Advance the model across one rising edge.
   task automatic commit();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int i = 0; i < 32; i++) begin
               m_regs[k][i] = 64'd0;
               m_pend[k][i] = 1'b0;
            end
         end else begin
            if (we && ix(k, rd) != 0) begin
               m_regs[k][ix(k, rd)] = indata & dmask(k);
               m_pend[k][ix(k, rd)] = 1'b0;
            end
            if (issue_valid && ix(k, issue_rd) != 0) m_pend[k][ix(k, issue_rd)] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic cycle();
      sample();
      commit();
   endtask

   task automatic idle();
      reset = 0; we = 0; rd = 0; indata = 0; rs1 = 0; rs2 = 0; issue_valid = 0; issue_rd = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      commit();
      reset = 0;

      // Every index reads zero and idle after reset.
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         cycle();
      end

      // Plain write then read on both ports.
      we = 1; rd = 5; indata = 64'hDEADBEEF;
      cycle();
      idle(); rs1 = 5; rs2 = 5;
      sample();
      check("wr5_a_rv2", {32'd0, rv2a}, 64'hDEADBEEF);
      check("wr5_b_rv1", rv1b, 64'hDEADBEEF);
      commit();

      // Same-cycle forwarding only on the bypass instance.
      we = 1; rd = 7; indata = 64'h12345678; rs1 = 7;
      sample();
      check("fwd_a_rv1", {32'd0, rv1a}, 64'h12345678);
      check("fwd_b_rv1", rv1b, 64'd0);
      commit();
      idle(); rs1 = 7;
      sample();
      check("fwd_b_next", rv1b, 64'h12345678);
      commit();

      // Register 0 ignores writes and issues.
      we = 1; rd = 0; indata = '1;
      cycle();
      idle(); issue_valid = 1; issue_rd = 0;
      cycle();
      idle();
      sample();
      check("r0_rv1", {32'd0, rv1a}, 64'd0);
      check("r0_busy", {63'd0, rs1_busy_a}, 64'd0);
      check("r0_any", {63'd0, any_busy_b}, 64'd0);
      commit();

      // Scoreboard: set, set-beats-clear, clear with and without bypass.
      issue_valid = 1; issue_rd = 3;
      cycle();
      idle(); rs2 = 3;
      sample();
      check("sb_set_a", {63'd0, rs2_busy_a}, 64'd1);
      check("sb_set_b", {63'd0, rs2_busy_b}, 64'd1);
      check("sb_any_a", {63'd0, any_busy_a}, 64'd1);
      commit();
      issue_valid = 1; issue_rd = 3; we = 1; rd = 3; indata = 64'h11;
      cycle();
      idle(); rs2 = 3;
      sample();
      check("sb_setwin", {63'd0, rs2_busy_a}, 64'd1);
      commit();
      we = 1; rd = 3; indata = 64'h22; rs2 = 3;
      sample();
      check("sb_fwd_a", {63'd0, rs2_busy_a}, 64'd0);
      check("sb_nofwd_b", {63'd0, rs2_busy_b}, 64'd1);
      commit();
      idle(); rs2 = 3;
      sample();
      check("sb_clr_a", {63'd0, rs2_busy_a}, 64'd0);
      check("sb_clr_any", {63'd0, any_busy_b}, 64'd0);
      commit();

      // Reset in the middle of activity drops the in-flight write and all pending state.
      we = 1; rd = 4; indata = 64'hA5; issue_valid = 1; issue_rd = 4;
      cycle();
      idle(); reset = 1; we = 1; rd = 4; indata = 64'h55;
      cycle();
      idle(); rs1 = 4; rs2 = 4;
      sample();
      check("rst_a_rv1", {32'd0, rv1a}, 64'd0);
      check("rst_b_rv2", rv2b, 64'd0);
      check("rst_busy", {63'd0, rs1_busy_a}, 64'd0);
      check("rst_any", {63'd0, any_busy_b}, 64'd0);
      commit();

      // Full-width value into the top register of the narrow-count instance.
      we = 1; rd = 15; indata = 64'h0123_4567_89AB_CDEF;
      cycle();
      idle(); rs1 = 15;
      sample();
      check("w64_b", rv1b, 64'h0123_4567_89AB_CDEF);
      check("w64_a", {32'd0, rv1a}, 64'h89AB_CDEF);
      commit();

      // Random traffic, biased toward a few low registers to provoke hazards.
      for (int n = 0; n < 2000; n++) begin
         bit narrow = ($urandom_range(0, 1) == 1);
         reset       = ($urandom_range(0, 99) == 0);
         we          = ($urandom_range(0, 2) != 0);
         rd          = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         indata      = {$urandom, $urandom};
         rs1         = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         rs2         = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_rd    = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's two-read/one-write integer register file. Adds configurable data width and register count, optional write-to-read bypass, synchronous clear-on-reset, and a per-register pending (scoreboard) bit so decode can detect RAW hazards.
- Sits between decode (read ports, issue port) and writeback (write port) of the pipelined core.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREGS, 32, number of architectural registers. Must be a power of 2, at least 2.
- AW, $clog2(NREGS), register index width. Derived; never overridden.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  writeback write enable
- rd  in  AW  writeback destination index
- indata  in  XLEN  writeback data
- rs1  in  AW  read port 1 index
- rv1  out  XLEN  read port 1 data
- rs2  in  AW  read port 2 index
- rv2  out  XLEN  read port 2 data
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  AW  destination of the issued instruction
- rs1_busy  out  1  rs1 has an outstanding producer
- rs2_busy  out  1  rs2 has an outstanding producer
- any_busy  out  1  OR of all pending bits

Behaviour:
- Storage: regs[0..NREGS-1], XLEN bits each; pend[0..NREGS-1], 1 bit each.
- Reset: at a clk edge with reset=1, all regs and all pend clear to 0. Reset overrides any simultaneous we or issue_valid.
- After reset: rv1 = rv2 = 0; rs1_busy = rs2_busy = any_busy = 0.
- Register 0 is hardwired zero:
  - writes with rd=0 are discarded;
  - reads of index 0 return 0 regardless of bypass;
  - pend[0] is never set.
- Write: at a clk edge with we=1, rd!=0 and reset=0, regs[rd] <= indata. One-cycle write latency.
- Read: combinational, zero latency.
  - rvN = 0 if rsN=0.
  - Otherwise, if BYPASS=1 and we=1 and rd=rsN, rvN = indata.
  - Otherwise rvN = regs[rsN].
  - Both ports may address the same register; both return identical data.
- Scoreboard update, per clk edge with reset=0, for register i != 0:
  - set_i = issue_valid and issue_rd=i.
  - clr_i = we and rd=i.
  - If set_i, pend[i] <= 1. Set wins over a simultaneous clr, because the new producer supersedes the retiring one.
  - Else if clr_i, pend[i] <= 0.
  - Else hold.
- Busy outputs, combinational:
  - rsN_busy = pend[rsN] and not (BYPASS=1 and we=1 and rd=rsN). The forwarded value satisfies the read this cycle.
  - rsN_busy = 0 when rsN=0.
  - any_busy = OR over pend[1..NREGS-1]; reflects registered state only.
- A write to a register with pend=0 is legal: data is stored, and pend stays 0.
- issue_valid to a register already pending is legal: pend stays 1. Tracking multiple outstanding producers is out of scope.
- Reset mid-operation: the in-flight write in the reset cycle is lost, and all pending state is dropped. The pipeline flushes alongside.
- No X on outputs: all storage is initialised via reset, and outputs are combinational from defined state.

Test Plan:
- Reset, then read all indices on both ports -> every rv = 0, rs1_busy = rs2_busy = any_busy = 0.
- we=1, rd=5, indata=0xDEADBEEF for one cycle; next cycle rs1=5, rs2=5 -> rv1 = rv2 = 0xDEADBEEF.
- Same-cycle forwarding: we=1, rd=7, indata=0x12345678, rs1=7.
  - BYPASS=1 -> rv1 = 0x12345678 in that cycle.
  - BYPASS=0 -> rv1 = old value (0) in that cycle, then 0x12345678 the following cycle.
- we=1, rd=0, indata=0xFFFFFFFF; then issue_valid=1, issue_rd=0; read rs1=0 -> rv1 = 0, rs1_busy = 0, any_busy = 0.
- Scoreboard sequence:
  - issue_rd=3 -> next cycle rs2=3 gives rs2_busy = 1 and any_busy = 1.
  - Same cycle issue_rd=3 and we=1, rd=3 -> pend[3] stays 1.
  - we=1, rd=3 alone, with BYPASS=1 -> rs2_busy = 0 that cycle, and pend[3] = 0 the following cycle.
- Mid-operation reset: pend[4]=1 and regs[4]=0xA5; assert reset with we=1, rd=4, indata=0x55 -> next cycle rv(4) = 0, rs_busy = 0, any_busy = 0.
- Parameter sweep (XLEN=64, NREGS=16, BYPASS=0) -> write/read 0x0123456789ABCDEF to reg 15, and all scenarios above pass.
